// File: rtl/loadrc.sv
// Run-time Toeplitz seed loader: assembles BS-bit stream words into the
// first row (rrow0, LSB word first) followed by the first column (col0).
module loadrc #(
  parameter int BS = 64,
  parameter int N  = 256,
  parameter int L  = 128
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [BS-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [N-1:0]  rrow0,
  output logic [L-1:0]  col0,
  output logic          seed_valid,
  output logic          busy,
  output logic          overflow
);

  localparam int NW = N / BS;
  localparam int LW = L / BS;
  localparam int CW = $clog2(NW + LW + 1);
  localparam logic [CW-1:0] ROW_LAST = CW'(NW - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(NW + LW - 1);

  typedef enum logic [1:0] {IDLE, LOAD_ROW, LOAD_COL, DONE} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            seed_valid_reg, seed_valid_next;
  logic            overflow_reg, overflow_next;
  logic [N-1:0]    rrow0_reg;
  logic [L-1:0]    col0_reg;
  logic            loading;
  logic            accept;
  logic [NW-1:0]   row_we;
  logic [LW-1:0]   col_we;

  assign loading = (state_reg == LOAD_ROW) || (state_reg == LOAD_COL);
  // start wins over a coincident handshake, so the restart begins cleanly at word 0
  assign accept  = in_valid && loading && !start;

  // The word counter runs across both segments; each slot decodes its own index.
  genvar gi;
  generate
    for (gi = 0; gi < NW; gi++) begin : g_row_we
      localparam logic [CW-1:0] IDX = CW'(gi);
      assign row_we[gi] = accept && (state_reg == LOAD_ROW) && (cnt_reg == IDX);
    end
    for (gi = 0; gi < LW; gi++) begin : g_col_we
      localparam logic [CW-1:0] IDX = CW'(NW + gi);
      assign col_we[gi] = accept && (state_reg == LOAD_COL) && (cnt_reg == IDX);
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      seed_valid_reg <= 1'b0;
      overflow_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      seed_valid_reg <= seed_valid_next;
      overflow_reg   <= overflow_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    seed_valid_next = seed_valid_reg;
    overflow_next   = overflow_reg;
    if (start) begin
      state_next      = LOAD_ROW;
      cnt_next        = '0;
      seed_valid_next = 1'b0;
      overflow_next   = 1'b0;
    end else begin
      case (state_reg)
        LOAD_ROW: begin
          if (in_valid) begin
            cnt_next = cnt_reg + CW'(1);
            if (cnt_reg == ROW_LAST) state_next = LOAD_COL;
          end
        end
        LOAD_COL: begin
          if (in_valid) begin
            cnt_next = cnt_reg + CW'(1);
            if (cnt_reg == COL_LAST) begin
              state_next      = DONE;
              seed_valid_next = 1'b1;
            end
          end
        end
        default: begin
          if (in_valid) overflow_next = 1'b1;
        end
      endcase
    end
  end

  // Unwritten words keep old contents; seed_valid is the only qualifier.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rrow0_reg <= '0;
      col0_reg  <= '0;
    end else begin
      for (int i = 0; i < NW; i++)
        if (row_we[i]) rrow0_reg[i*BS +: BS] <= in_data;
      for (int i = 0; i < LW; i++)
        if (col_we[i]) col0_reg[i*BS +: BS] <= in_data;
    end
  end

  assign in_ready   = loading;
  assign busy       = loading;
  assign rrow0      = rrow0_reg;
  assign col0       = col0_reg;
  assign seed_valid = seed_valid_reg;
  assign overflow   = overflow_reg;

endmodule

// File: tb/tb_loadrc.sv
// Self-checking bench for loadrc: directed scenarios plus random traffic,
// compared cycle by cycle against a word-level reference model.
module tb_loadrc;

  localparam int BS = 64;
  localparam int N  = 256;
  localparam int L  = 128;
  localparam int NW = N / BS;
  localparam int LW = L / BS;
  localparam logic [N-1:0] PAT_ROW =
    256'h0123456789abcdef_fedcba9876543210_a5a5a5a55a5a5a5a_deadbeefcafef00d;
  localparam logic [L-1:0] PAT_COL =
    128'h8000000000000001_13579bdf2468ace0;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [BS-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  rrow0;
  logic [L-1:0]  col0;
  logic          seed_valid;
  logic          busy;
  logic          overflow;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: a "loading" flag, a count of words taken since start,
  // and the seed vectors as they should look.
  logic         m_loading;
  int           m_k;
  logic         m_sv;
  logic         m_ov;
  logic [N-1:0] m_row;
  logic [L-1:0] m_col;

  loadrc #(.BS(BS), .N(N), .L(L)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .rrow0      (rrow0),
    .col0       (col0),
    .seed_valid (seed_valid),
    .busy       (busy),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_loading = 1'b0;
    m_k       = 0;
    m_sv      = 1'b0;
    m_ov      = 1'b0;
    m_row     = '0;
    m_col     = '0;
  endtask

  task automatic model_edge(input logic s, input logic v, input logic [BS-1:0] d);
    if (s) begin
      m_loading = 1'b1;
      m_k       = 0;
      m_sv      = 1'b0;
      m_ov      = 1'b0;
    end else if (m_loading && v) begin
      if (m_k < NW) m_row[m_k*BS +: BS] = d;
      else          m_col[(m_k-NW)*BS +: BS] = d;
      m_k++;
      if (m_k == NW + LW) begin
        m_loading = 1'b0;
        m_sv      = 1'b1;
      end
    end else if (!m_loading && v) begin
      m_ov = 1'b1;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".rrow0"},      rrow0,                   m_row);
    chk({tag, ".col0"},       256'(col0),              256'(m_col));
    chk({tag, ".seed_valid"}, 256'(seed_valid),        256'(m_sv));
    chk({tag, ".busy"},       256'(busy),              256'(m_loading));
    chk({tag, ".in_ready"},   256'(in_ready),          256'(m_loading));
    chk({tag, ".overflow"},   256'(overflow),          256'(m_ov));
  endtask

  // One clock: drive, let the edge happen, update the model, check 1ns later.
  task automatic step(input string tag, input logic s, input logic v, input logic [BS-1:0] d);
    start    = s;
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    model_edge(s, v, d);
    #1;
    check_all(tag);
    $display("cyc %s start=%0b valid=%0b data=%h sv=%0b busy=%0b ov=%0b",
             tag, s, v, d, seed_valid, busy, overflow);
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    logic [N-1:0] pr;
    logic [L-1:0] pc;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    reset_n  = 1'b0;
    model_reset();

    // 1. reset
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    reset_n = 1'b1;

    // 2. full load, valid held high
    step("t2", 1'b1, 1'b0, '0);
    for (int i = 0; i < NW + LW; i++) step("t2", 1'b0, 1'b1, BS'(i));
    chk("t2.row_const", rrow0, {64'h3, 64'h2, 64'h1, 64'h0});
    chk("t2.col_const", 256'(col0), 256'({64'h5, 64'h4}));
    step("t2_idle", 1'b0, 1'b0, '0);

    // 3. valid toggling
    step("t3", 1'b1, 1'b0, '0);
    for (int i = 0; i < 2 * (NW + LW); i++)
      step("t3", 1'b0, (i % 2) == 0, BS'(i / 2));
    chk("t3.row_const", rrow0, {64'h3, 64'h2, 64'h1, 64'h0});
    chk("t3.col_const", 256'(col0), 256'({64'h5, 64'h4}));

    // 4. restart after 3 row words; coincident handshake must be ignored
    step("t4", 1'b1, 1'b0, '0);
    for (int i = 0; i < 3; i++) step("t4", 1'b0, 1'b1, BS'(64'h10 + i));
    step("t4_restart", 1'b1, 1'b1, 64'hdead);
    for (int i = 0; i < NW + LW; i++) step("t4", 1'b0, 1'b1, BS'(64'hA0 + i));
    chk("t4.row_const", rrow0, {64'hA3, 64'hA2, 64'hA1, 64'hA0});
    chk("t4.col_const", 256'(col0), 256'({64'hA5, 64'hA4}));

    // 5. overflow in DONE, cleared by start
    step("t5_ovf", 1'b0, 1'b1, 64'hffff_ffff_ffff_ffff);
    chk("t5.row_hold", rrow0, {64'hA3, 64'hA2, 64'hA1, 64'hA0});
    step("t5_clear", 1'b1, 1'b0, '0);

    // 6. async reset mid-load, then load the reference pattern
    for (int i = 0; i < 4; i++) step("t6", 1'b0, 1'b1, BS'(64'h77 + i));
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all("t6_async_reset");
    #2;
    reset_n = 1'b1;
    pr = PAT_ROW;
    pc = PAT_COL;
    step("t6_pat", 1'b1, 1'b0, '0);
    for (int i = 0; i < NW; i++) step("t6_pat", 1'b0, 1'b1, pr[i*BS +: BS]);
    for (int i = 0; i < LW; i++) step("t6_pat", 1'b0, 1'b1, pc[i*BS +: BS]);
    chk("t6.row_const", rrow0, PAT_ROW);
    chk("t6.col_const", 256'(col0), 256'(PAT_COL));
    chk("t6.sv_const", 256'(seed_valid), 256'(1));

    // 7. random traffic
    for (int i = 0; i < 400; i++) begin
      logic s, v;
      logic [BS-1:0] d;
      s = ($urandom_range(0, 19) == 0);
      v = ($urandom_range(0, 2) != 0);
      d = {$urandom, $urandom};
      step("rand", s, v, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
